// File: rtl/fm_mult_pipe.sv
// fm_mult_pipe: pipelined front end of the floating-point multiplier.
// Computes the result sign and the re-biased exponent sum, and forms the
// unnormalised significand product with an array multiplier split over
// NSTG = ceil((MW+1)/ROWS_PER_STAGE) stages.
// Optional macro FM_SPECIAL_EN: classify zero/inf/NaN operands and raise
// the flags; without it every operand is treated as a normal number.
module fm_mult_pipe #(
  parameter int EW             = 5,
  parameter int MW             = 10,
  parameter int OUT_EW         = 8,
  parameter int OUT_BIAS       = 127,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EW+MW:0]       A,
  input  logic [EW+MW:0]       B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [OUT_EW-1:0]    out_exp,
  output logic [2*(MW+1)-1:0]  out_prod,
  output logic                 out_zero,
  output logic                 out_inf,
  output logic                 out_nan
);
  localparam int SW      = MW + 1;
  localparam int PW      = 2 * SW;
  localparam int NSTG    = (SW + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  localparam int BIAS_IN = (1 << (EW - 1)) - 1;
  localparam logic [OUT_EW-1:0] EXP_OFF = OUT_EW'(OUT_BIAS - 2 * BIAS_IN);

  logic              stall;
  logic              sign_a, sign_b;
  logic [EW-1:0]     exp_a, exp_b;
  logic [MW-1:0]     frac_a, frac_b;
  logic              flag_zero, flag_inf, flag_nan, special;
  logic [OUT_EW-1:0] exp_sum;
  logic [SW-1:0]     sga_first;

  assign sign_a = A[EW+MW];
  assign sign_b = B[EW+MW];
  assign exp_a  = A[EW+MW-1:MW];
  assign exp_b  = B[EW+MW-1:MW];
  assign frac_a = A[MW-1:0];
  assign frac_b = B[MW-1:0];

`ifdef FM_SPECIAL_EN
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  assign zero_a    = (exp_a == '0);
  assign zero_b    = (exp_b == '0);
  assign inf_a     = (&exp_a) && (frac_a == '0);
  assign inf_b     = (&exp_b) && (frac_b == '0);
  assign nan_a     = (&exp_a) && (frac_a != '0);
  assign nan_b     = (&exp_b) && (frac_b != '0);
  // NaN wins over inf, inf wins over zero
  assign flag_nan  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
  assign flag_inf  = !flag_nan && (inf_a || inf_b);
  assign flag_zero = !flag_nan && !flag_inf && (zero_a || zero_b);
`else
  assign flag_zero = 1'b0;
  assign flag_inf  = 1'b0;
  assign flag_nan  = 1'b0;
`endif

  assign special = flag_zero | flag_inf | flag_nan;

  // Exponent sum wraps modulo 2^OUT_EW; no saturation
  assign exp_sum = OUT_EW'(exp_a) + OUT_EW'(exp_b) + EXP_OFF;

  // Zeroing one significand makes the whole product array sum to zero
  assign sga_first = special ? '0 : {1'b1, frac_a};

  // One global stall freezes every stage while the head result waits
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  genvar gi;
  for (gi = 0; gi < NSTG; gi++) begin : g_stage
    localparam int LO = gi * ROWS_PER_STAGE;
    localparam int HI = (LO + ROWS_PER_STAGE > SW) ? SW : LO + ROWS_PER_STAGE;

    logic              valid_in, sign_in, zero_in, inf_in, nan_in;
    logic [OUT_EW-1:0] exp_in;
    logic [PW-1:0]     sum_in, sum_next;
    logic [SW-1:0]     sga_in;
    // Only the multiplier bits of rows not yet summed reach this stage
    logic [SW-LO-1:0]  sgb_in;

    logic              valid_reg, sign_reg, zero_reg, inf_reg, nan_reg;
    logic [OUT_EW-1:0] exp_reg;
    logic [PW-1:0]     sum_reg;

    if (gi == 0) begin : g_src
      assign valid_in = in_valid;
      assign sign_in  = sign_a ^ sign_b;
      assign zero_in  = flag_zero;
      assign inf_in   = flag_inf;
      assign nan_in   = flag_nan;
      assign exp_in   = special ? '0 : exp_sum;
      assign sum_in   = '0;
      assign sga_in   = sga_first;
      assign sgb_in   = {1'b1, frac_b};
    end else begin : g_src
      assign valid_in = g_stage[gi-1].valid_reg;
      assign sign_in  = g_stage[gi-1].sign_reg;
      assign zero_in  = g_stage[gi-1].zero_reg;
      assign inf_in   = g_stage[gi-1].inf_reg;
      assign nan_in   = g_stage[gi-1].nan_reg;
      assign exp_in   = g_stage[gi-1].exp_reg;
      assign sum_in   = g_stage[gi-1].sum_reg;
      assign sga_in   = g_stage[gi-1].g_ops.sga_reg;
      assign sgb_in   = g_stage[gi-1].g_ops.sgb_reg;
    end

    // Ripple-add this stage's partial-product rows onto the running sum
    always_comb begin
      sum_next = sum_in;
      for (int r = LO; r < HI; r++) begin
        if (sgb_in[r-LO]) sum_next = sum_next + (PW'(sga_in) << r);
      end
    end

    // Stage register: cleared on reset, held while stalled
    always_ff @(posedge CLK) begin
      if (RESET) begin
        valid_reg <= 1'b0;
        sign_reg  <= 1'b0;
        zero_reg  <= 1'b0;
        inf_reg   <= 1'b0;
        nan_reg   <= 1'b0;
        exp_reg   <= '0;
        sum_reg   <= '0;
      end else if (!stall) begin
        valid_reg <= valid_in;
        sign_reg  <= sign_in;
        zero_reg  <= zero_in;
        inf_reg   <= inf_in;
        nan_reg   <= nan_in;
        exp_reg   <= exp_in;
        sum_reg   <= sum_next;
      end
    end

    if (gi < NSTG - 1) begin : g_ops
      logic [SW-1:0]    sga_reg;
      logic [SW-HI-1:0] sgb_reg;
      // Forward the multiplicand and the remaining multiplier bits
      always_ff @(posedge CLK) begin
        if (RESET) begin
          sga_reg <= '0;
          sgb_reg <= '0;
        end else if (!stall) begin
          sga_reg <= sga_in;
          sgb_reg <= sgb_in[SW-LO-1:HI-LO];
        end
      end
    end
  end

  assign out_valid = g_stage[NSTG-1].valid_reg;
  assign out_sign  = g_stage[NSTG-1].sign_reg;
  assign out_exp   = g_stage[NSTG-1].exp_reg;
  assign out_prod  = g_stage[NSTG-1].sum_reg;
  assign out_zero  = g_stage[NSTG-1].zero_reg;
  assign out_inf   = g_stage[NSTG-1].inf_reg;
  assign out_nan   = g_stage[NSTG-1].nan_reg;

endmodule

// File: tb/tb_fm_mult_pipe.sv
// tb_fm_mult_pipe: randomized bench for fm_mult_pipe against an arithmetic
// reference model. Three instances (2, 1 and 11 rows per stage) share the
// input stream; only the default instance sees back-pressure.
module tb_fm_mult_pipe;
  localparam int OUT_BIAS = 127;
  localparam int BIAS_IN  = 15;
  localparam int NSTG_K [3] = '{6, 11, 1};

  typedef struct {
    int          inst;
    logic        sign;
    logic [7:0]  exp;
    logic [21:0] prod;
    logic [2:0]  flags;
    int          stamp;
  } exp_t;

  logic        CLK, RESET, in_valid;
  logic [15:0] A, B;
  logic        ir [3];
  logic        ov [3];
  logic        ordy [3];
  logic        osign [3];
  logic [7:0]  oexp [3];
  logic [21:0] oprod [3];
  logic        oz [3], oi [3], on [3];

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 0;
  bit   lat_chk = 0;
  bit   rnd_done = 0;

  fm_mult_pipe #(.ROWS_PER_STAGE(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(ir[0]),
    .A(A), .B(B), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sign(osign[0]), .out_exp(oexp[0]), .out_prod(oprod[0]),
    .out_zero(oz[0]), .out_inf(oi[0]), .out_nan(on[0]));

  fm_mult_pipe #(.ROWS_PER_STAGE(1)) u_dut_r1 (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(ir[1]),
    .A(A), .B(B), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sign(osign[1]), .out_exp(oexp[1]), .out_prod(oprod[1]),
    .out_zero(oz[1]), .out_inf(oi[1]), .out_nan(on[1]));

  fm_mult_pipe #(.ROWS_PER_STAGE(11)) u_dut_r11 (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(ir[2]),
    .A(A), .B(B), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_sign(osign[2]), .out_exp(oexp[2]), .out_prod(oprod[2]),
    .out_zero(oz[2]), .out_inf(oi[2]), .out_nan(on[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: plain integer multiply of the significands, bias arithmetic
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int ea, eb, fa, fb;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    fa = int'(a[9:0]);
    fb = int'(b[9:0]);
    r.inst  = 0;
    r.stamp = 0;
    r.sign  = a[15] ^ b[15];
    r.exp   = 8'((ea + eb + OUT_BIAS - 2 * BIAS_IN) % 256);
    r.prod  = 22'((1024 + fa) * (1024 + fb));
    r.flags = 3'b000;
`ifdef FM_SPECIAL_EN
    begin
      bit za, zb, ia, ib, na, nb;
      za = (ea == 0);
      zb = (eb == 0);
      ia = (ea == 31) && (fa == 0);
      ib = (eb == 31) && (fb == 0);
      na = (ea == 31) && (fa != 0);
      nb = (eb == 31) && (fb != 0);
      if (na || nb || (ia && zb) || (ib && za)) r.flags = 3'b001;
      else if (ia || ib)                        r.flags = 3'b010;
      else if (za || zb)                        r.flags = 3'b100;
      if (r.flags != 3'b000) begin
        r.prod = '0;
        r.exp  = '0;
      end
    end
`endif
    return r;
  endfunction

  function automatic logic [15:0] rand_normal();
    logic [15:0] v;
    v[15]    = 1'($urandom_range(0, 1));
    v[14:10] = 5'($urandom_range(1, 30));
    v[9:0]   = 10'($urandom);
    return v;
  endfunction

  // Scoreboard: check results as they leave, record inputs as they enter
  always @(negedge CLK) begin : mon
    exp_t e;
    int   idx;
    if (mon_en && !RESET) begin
      check_value("in_ready", 32'(ir[0]), 32'(!(ov[0] && !ordy[0])));
      for (int k = 0; k < 3; k++) begin
        if (ov[k] && ordy[k]) begin
          idx = -1;
          foreach (q[j]) if (idx < 0 && q[j].inst == k) idx = j;
          $display("txn inst=%0d sign=%0d exp=%0d prod=%06h flags=%03b",
                   k, osign[k], oexp[k], oprod[k], {oz[k], oi[k], on[k]});
          if (idx < 0) begin
            check_value("unexpected_out", 32'(ov[k]), 32'd0);
          end else begin
            e = q[idx];
            q.delete(idx);
            check_value("sign", 32'(osign[k]), 32'(e.sign));
            check_value("exp", 32'(oexp[k]), 32'(e.exp));
            check_value("prod", 32'(oprod[k]), 32'(e.prod));
            check_value("flags", 32'({oz[k], oi[k], on[k]}), 32'(e.flags));
            if (k != 0 || lat_chk) check_value("latency", 32'(cyc - e.stamp), 32'(NSTG_K[k]));
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (in_valid && ir[k]) begin
          e = model(A, B);
          e.inst  = k;
          e.stamp = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    in_valid = 1'b1;
    A = a;
    B = b;
    @(negedge CLK);
    while (!ir[0] && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) check_value("send_timeout", 32'(ir[0]), 32'd1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge CLK);
      t++;
    end
    check_value("drain_pending", 32'(q.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    ordy[2] = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_value("rst_out_valid", 32'(ov[k]), 32'd0);
      check_value("rst_sign", 32'(osign[k]), 32'd0);
      check_value("rst_exp", 32'(oexp[k]), 32'd0);
      check_value("rst_prod", 32'(oprod[k]), 32'd0);
      check_value("rst_flags", 32'({oz[k], oi[k], on[k]}), 32'd0);
    end
    RESET = 1'b0;
    @(negedge CLK);
    check_value("rst_in_ready", 32'(ir[0]), 32'd1);
    @(posedge CLK);
    #1;
    mon_en  = 1'b1;
    lat_chk = 1'b1;

    // Directed arithmetic
    send(16'h3C00, 16'h3C00);
    drain();
    send(16'h4000, 16'h4200);
    send(16'hC000, 16'h4200);
    drain();

    // Special operands (flagged only when classification is built in)
    send(16'h0000, 16'h4200);
    send(16'h7C00, 16'h3C00);
    send(16'h7C00, 16'h0000);
    send(16'h7E00, 16'h3C00);
    drain();

    // Normal stream with a 4-cycle stall in the middle
    lat_chk = 1'b0;
    fork
      for (int i = 0; i < 10; i++) send(rand_normal(), rand_normal());
      begin
        repeat (7) @(posedge CLK);
        #1 ordy[0] = 1'b0;
        repeat (4) @(posedge CLK);
        #1 ordy[0] = 1'b1;
      end
    join
    drain();

    // Fully random operands, random bubbles, random back-pressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK);
            #1;
          end
          send(16'($urandom), 16'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge CLK);
          #1 ordy[0] = ($urandom_range(0, 3) != 0);
        end
        ordy[0] = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;

    // Reset while three results are in flight and stalled
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_normal(), rand_normal());
    for (int t = 0; t < 50 && !ov[0]; t++) @(negedge CLK);
    check_value("stall_reached", 32'(ov[0]), 32'd1);
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    q.delete();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) check_value("rst_flush_valid", 32'(ov[k]), 32'd0);
    @(posedge CLK);
    #1;
    ordy[0] = 1'b1;
    send(16'h4000, 16'h4200);
    drain();
    repeat (15) @(posedge CLK);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fm_mult_pipe.md
# fm_mult_pipe

Parametrised, fully pipelined front end of the floating-point multiplier in the MAC datapath. It accepts two IEEE-style operands with a valid/ready handshake and computes the result sign and the re-biased exponent sum. It forms the unnormalised significand product with an array multiplier split across a configurable number of pipeline stages, and flags special operands. Its output feeds the normalise/round stage and the accumulator unchanged.

## Interface
- EW, 5: operand exponent width.
- MW, 10: operand stored-fraction width; significand is MW+1 bits with hidden 1.
- OUT_EW, 8: output exponent width.
- OUT_BIAS, 127: bias of the output exponent.
- ROWS_PER_STAGE, 2: partial-product rows accumulated per pipeline stage, 1..MW+1.
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept this cycle.
- A, B  in  1+EW+MW each  operands {sign, exponent, fraction}.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sign  out  1  result sign.
- out_exp  out  OUT_EW  re-biased exponent sum.
- out_prod  out  2*(MW+1)  unnormalised significand product.
- out_zero, out_inf, out_nan  out  1 each  special-case flags.

## Operation
- Input bias is BIAS_IN = 2^(EW-1)-1. The exponent is computed as ex_A + ex_B + (OUT_BIAS - 2*BIAS_IN), modulo 2^OUT_EW. With the defaults this is ex_A + ex_B + 97.
- Parameters must satisfy OUT_BIAS >= 2*BIAS_IN and OUT_BIAS + 2*(2^EW-2-BIAS_IN) < 2^OUT_EW. Outside that range the result wraps; there is no saturation.
- out_sign = A.sign XOR B.sign for every input, including specials.
- Significands are {1, fraction}. Partial product i = sgA AND sgB[i], shifted left i, for i = 0..MW.
- NSTG = ceil((MW+1)/ROWS_PER_STAGE). Stage 1 registers the sum of rows 0..R-1, where R = ROWS_PER_STAGE. Stage k adds rows (k-1)R..kR-1 to the running sum. Unused rows and their registers are dropped, not carried.
- The running sum is a full-width 2*(MW+1)-bit ripple adder per row. There is no truncation.
- Sign, exponent, flags and the valid bit travel alongside the sum through all NSTG stages.
- The handshake uses a global stall: stall = out_valid AND NOT out_ready, and in_ready = NOT stall.
- While stall is high, every stage register holds its value. A transfer occurs only when in_valid AND in_ready are both high.
- When not stalled, each stage's valid bit shifts forward. An empty input slot inserts a bubble with valid 0.
- out_* data may take any value while out_valid is 0. The bench checks data only when valid is high.

## Timing
- Latency is exactly NSTG cycles from the accepting edge to out_valid, absent stalls; with the defaults NSTG = 6.
- Throughput is one result per cycle. A stall of N cycles delays every in-flight result by N cycles and preserves their order.
- Simultaneous cases:
  - out_ready rising in the same cycle as in_valid: the input is accepted and the head result leaves on the same edge.
  - out_valid low: never stalls, even if out_ready is low.
- Reset applies on the edge where RESET is high. All valid bits clear and in-flight results are discarded, even if stalled.
- Reset values: out_valid 0, out_sign 0, out_exp 0, out_prod 0, all flags 0. in_ready is 1 from the cycle after reset.

## Configuration
- FM_SPECIAL_EN defined:
  - An operand is zero if its exponent is 0; subnormals flush to zero.
  - An operand is infinite if its exponent is all ones and its fraction is 0, and NaN if its exponent is all ones and its fraction is non-zero.
  - out_nan is set for any NaN operand, or for inf times zero.
  - Otherwise out_inf is set for any inf operand, and otherwise out_zero is set for any zero operand.
  - Whenever out_zero, out_inf or out_nan is set, out_prod is forced to 0 and out_exp to 0.
- FM_SPECIAL_EN undefined:
  - All three flags are tied to 0.
  - Every operand is treated as normal with a hidden 1, so exponent 0 and all-ones exponents are multiplied arithmetically.

## Test plan
- Defaults, out_ready high: 0x3C00 x 0x3C00 -> after 6 cycles out_valid=1, sign 0, exp 127, prod 22'h100000.
- 0x4000 x 0x4200, then 0xC000 x 0x4200 back-to-back -> two consecutive outputs with exp 129, prod 22'h180000; sign 0 then 1.
- Stream 10 random normal pairs; hold out_ready low for 4 cycles mid-stream -> in_ready low during the stall, no loss or reordering, all results match the reference model.
- FM_SPECIAL_EN defined:
  - 0x0000 x 0x4200 -> out_zero=1, prod 0.
  - 0x7C00 x 0x3C00 -> out_inf=1.
  - 0x7C00 x 0x0000 -> out_nan=1.
  - 0x7E00 x 0x3C00 -> out_nan=1.
- ROWS_PER_STAGE=1 (NSTG=11) and ROWS_PER_STAGE=11 (NSTG=1) -> latency matches NSTG, products equal those of the default configuration.
- RESET high for one cycle while 3 results are in flight and stalled -> out_valid 0 next cycle, no stale result ever appears, next accepted input emerges after NSTG cycles.
